// File: rtl/node_tx_frame_queue.sv
// Per-node transmit queue: button-entered frames drained to the switch ingress.
// Optional DROP_COUNT_EN adds a saturating count of adds dropped on a full queue.
module node_tx_frame_queue #(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 4,
  parameter int PAYLOAD_W  = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                   FPGA_CLK,
  input  logic                   FPGA_RST_BTN,
  input  logic                   add_btn,
  input  logic                   send_btn,
  input  logic [ADDR_W-1:0]      dst_addr,
  input  logic [ADDR_W-1:0]      src_addr,
  input  logic [PAYLOAD_W-1:0]   payload,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [ADDR_W-1:0]      tx_dst,
  output logic [ADDR_W-1:0]      tx_src,
  output logic [PAYLOAD_W-1:0]   tx_payload,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   q_full,
  output logic                   q_empty,
  output logic                   busy
`ifdef DROP_COUNT_EN
  ,
  output logic [7:0]             drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = 2 * ADDR_W + PAYLOAD_W;
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    GAP
  } state_t;

  state_t          state;
  logic [2:0]      add_sh;
  logic [2:0]      send_sh;
  logic            add_pulse;
  logic            send_pulse;
  logic            push;
  logic            pop;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [FW-1:0]   mem [DEPTH];
  logic [FW-1:0]   head;
  logic [GW-1:0]   gap_cnt;

  // [0],[1] synchronize; [2] remembers the previous level for edge detect
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_BTN) begin
    if (!FPGA_RST_BTN) begin
      add_sh  <= '0;
      send_sh <= '0;
    end else begin
      add_sh  <= {add_sh[1:0], add_btn};
      send_sh <= {send_sh[1:0], send_btn};
    end
  end

  assign add_pulse  = add_sh[1] & ~add_sh[2];
  assign send_pulse = send_sh[1] & ~send_sh[2];

  assign q_full  = (q_count == CW'(DEPTH));
  assign q_empty = (q_count == '0);
  assign busy    = (state != IDLE);

  assign push = add_pulse & ~q_full;
  assign pop  = (state == LOAD);
  assign head = mem[rd_ptr];

  always_ff @(posedge FPGA_CLK) begin
    if (push) mem[wr_ptr] <= {dst_addr, src_addr, payload};
  end

  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_BTN) begin
    if (!FPGA_RST_BTN) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      q_count <= q_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_BTN) begin
    if (!FPGA_RST_BTN) begin
      state      <= IDLE;
      tx_valid   <= 1'b0;
      tx_dst     <= '0;
      tx_src     <= '0;
      tx_payload <= '0;
      gap_cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (send_pulse && !q_empty) state <= LOAD;
        end
        LOAD: begin
          {tx_dst, tx_src, tx_payload} <= head;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            gap_cnt  <= '0;
            if (q_empty)              state <= IDLE;
            else if (GAP_CYCLES == 0) state <= LOAD;
            else                      state <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= LOAD;
          else gap_cnt <= gap_cnt + GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DROP_COUNT_EN
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_BTN) begin
    if (!FPGA_RST_BTN) begin
      drop_cnt <= '0;
    end else if (add_pulse && q_full && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_node_tx_frame_queue.sv
// Scoreboard bench for node_tx_frame_queue: accepted frames are queued as
// expected handshakes and a negedge monitor pops them in order.
module tb_node_tx_frame_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 4;
  localparam int PLW   = 4;
  localparam int GAP   = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef logic [2*AW+PLW-1:0] frame_t;

  logic           clk;
  logic           rst_n;
  logic           add_btn;
  logic           send_btn;
  logic [AW-1:0]  dst_addr;
  logic [AW-1:0]  src_addr;
  logic [PLW-1:0] payload;
  logic           tx_valid;
  logic           tx_ready;
  logic [AW-1:0]  tx_dst;
  logic [AW-1:0]  tx_src;
  logic [PLW-1:0] tx_payload;
  logic [CW-1:0]  q_count;
  logic           q_full;
  logic           q_empty;
  logic           busy;
`ifdef DROP_COUNT_EN
  logic [7:0]     drop_cnt;
`endif

  node_tx_frame_queue #(
    .DEPTH(DEPTH), .ADDR_W(AW), .PAYLOAD_W(PLW), .GAP_CYCLES(GAP)
  ) dut (
    .FPGA_CLK(clk),
    .FPGA_RST_BTN(rst_n),
    .add_btn(add_btn),
    .send_btn(send_btn),
    .dst_addr(dst_addr),
    .src_addr(src_addr),
    .payload(payload),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_dst(tx_dst),
    .tx_src(tx_src),
    .tx_payload(tx_payload),
    .q_count(q_count),
    .q_full(q_full),
    .q_empty(q_empty),
    .busy(busy)
`ifdef DROP_COUNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  int     vectors = 0;
  int     miscompares = 0;
  int     cyc = 0;
  int     ready_mode = 0;
  int     model_occ = 0;
  int     model_drops = 0;
  frame_t exp_q[$];
  int     hs_cyc[$];
  frame_t mon_f;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Handshake monitor: inputs change just after posedge, so a negedge
  // sample of valid&&ready predicts the transfer at the next posedge.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      mon_f = {tx_dst, tx_src, tx_payload};
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_frame: got %0h expected none", mon_f);
      end else begin
        check("frame_order", 32'(mon_f), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: tx_ready = 1'b0;
        1: tx_ready = 1'b1;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add_frame(logic [AW-1:0] d, logic [AW-1:0] s,
                           logic [PLW-1:0] p, int hold, bit chk);
    if (model_occ < DEPTH) begin
      exp_q.push_back({d, s, p});
      model_occ++;
    end else begin
      model_drops++;
    end
    tick(1);
    dst_addr = d;
    src_addr = s;
    payload  = p;
    add_btn  = 1'b1;
    tick(hold);
    add_btn = 1'b0;
    tick(3);
    if (chk) begin
      check("q_count_after_add", 32'(q_count), 32'(model_occ));
      check("q_full_after_add", 32'(q_full), 32'(model_occ == DEPTH));
    end
  endtask

  task automatic press_send();
    tick(1);
    send_btn = 1'b1;
    tick(2);
    send_btn = 1'b0;
    tick(1);
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
    check("q_count_after_burst", 32'(q_count), 32'd0);
    check("q_empty_after_burst", 32'(q_empty), 32'd1);
    model_occ = 0;
  endtask

  task automatic wait_valid(int budget);
    int n = 0;
    while (!tx_valid && n < budget) begin
      tick(1);
      n++;
    end
    check("valid_timeout", 32'(tx_valid), 32'd1);
  endtask

  task automatic check_drops();
`ifdef DROP_COUNT_EN
    check("drop_cnt", 32'(drop_cnt),
          32'((model_drops > 255) ? 255 : model_drops));
`endif
  endtask

  initial begin
    frame_t held;
    int     unstable;
    rst_n    = 1'b0;
    add_btn  = 1'b0;
    send_btn = 1'b0;
    dst_addr = '0;
    src_addr = '0;
    payload  = '0;
    #12;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_fields", 32'({tx_dst, tx_src, tx_payload}), 32'd0);
    check("rst_q_count", 32'(q_count), 32'd0);
    check("rst_q_empty", 32'(q_empty), 32'd1);
    check("rst_q_full", 32'(q_full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_drops();
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Three frames with exact spacing at full ready
    add_frame(4'hC, 4'hA, 4'h5, 2, 1);
    add_frame(4'hD, 4'hB, 4'h5, 2, 1);
    add_frame(4'hA, 4'hC, 4'h5, 2, 1);
    ready_mode = 1;
    tick(2);
    hs_cyc.delete();
    press_send();
    wait_idle(200);
    check("burst_len", 32'(hs_cyc.size()), 32'd3);
    if (hs_cyc.size() == 3) begin
      check("spacing_1", 32'(hs_cyc[1] - hs_cyc[0]), 32'(2 + GAP));
      check("spacing_2", 32'(hs_cyc[2] - hs_cyc[1]), 32'(2 + GAP));
    end

    // Held button gives a single add; empty send is ignored
    add_frame(4'h1, 4'h2, 4'h3, 50, 1);
    press_send();
    wait_idle(200);
    press_send();
    check("empty_send_ignored", 32'(busy), 32'd0);

    // Overfill
    for (int i = 0; i < DEPTH + 2; i++)
      add_frame(4'(i), 4'(15 - i), 4'(i + 3), 1, 1);
    check("full_flag", 32'(q_full), 32'd1);
    check_drops();
    press_send();
    wait_idle(300);

    // Stall with ready low; a second send is ignored
    add_frame(4'h7, 4'h7, 4'h9, 1, 1);
    add_frame(4'h3, 4'h4, 4'hE, 1, 1);
    ready_mode = 0;
    tick(2);
    press_send();
    wait_valid(20);
    held = {tx_dst, tx_src, tx_payload};
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 8) begin
        send_btn = 1'b1;
        tick(2);
        send_btn = 1'b0;
        i = i + 2;
      end
      tick(1);
      if (!tx_valid || {tx_dst, tx_src, tx_payload} !== held) unstable++;
    end
    check("stall_stable", 32'(unstable), 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    ready_mode = 1;
    wait_idle(200);
    tick(6);
    check("no_rearm", 32'(busy), 32'd0);

    // Add during SEND joins the running burst
    ready_mode = 0;
    tick(2);
    add_frame(4'h5, 4'h6, 4'h1, 1, 1);
    press_send();
    wait_valid(20);
    add_frame(4'h9, 4'h8, 4'h2, 1, 0);
    check("late_add_queued", 32'(q_count), 32'd1);
    ready_mode = 1;
    wait_idle(200);

    // Randomized bursts
    for (int it = 0; it < 20; it++) begin
      int n = $urandom_range(1, DEPTH + 3);
      ready_mode = 0;
      for (int k = 0; k < n; k++)
        add_frame(4'($urandom), 4'($urandom), 4'($urandom),
                  $urandom_range(1, 3), 1);
      check_drops();
      ready_mode = $urandom_range(1, 2);
      press_send();
      wait_idle(2000);
    end

    // Asynchronous reset in the middle of a stalled burst
    ready_mode = 0;
    tick(2);
    add_frame(4'hE, 4'h1, 4'h4, 1, 1);
    add_frame(4'hF, 4'h2, 4'h6, 1, 1);
    press_send();
    wait_valid(20);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_q_count", 32'(q_count), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_q_empty", 32'(q_empty), 32'd1);
    exp_q.delete();
    model_occ = 0;
    model_drops = 0;
    check_drops();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    add_frame(4'h2, 4'hD, 4'hB, 1, 1);
    ready_mode = 1;
    press_send();
    wait_idle(200);

    tick(4);
    check("leftover_frames", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
